// File: rtl/life_step_engine_if.sv
// Selector-port bus between the life step engine and the 4x16 cell memory,
// plus the engine's start/status handshake.
interface life_step_engine_if;
    logic        start;
    logic [1:0]  array_selector;
    logic [15:0] alive_out_selector;
    logic [15:0] alive_in_selector;
    logic        write_enb;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;

    modport master (
        input  start,
        input  alive_out_selector,
        output array_selector,
        output alive_in_selector,
        output write_enb,
        output busy,
        output done,
        output gen_count
    );

    modport slave (
        output start,
        output alive_out_selector,
        input  array_selector,
        input  alive_in_selector,
        input  write_enb,
        input  busy,
        input  done,
        input  gen_count
    );
endinterface

// File: rtl/life_step_engine.sv
// Game of Life generation step over a 4x16 row memory: read all rows, compute
// B3/S23 in one cycle, then write all rows back.
//
// state   | meaning
// IDLE    | waiting for start
// READ    | presenting row addresses 0..3 and capturing returned rows
// COMPUTE | next generation evaluated from cur_q and registered into nxt_q
// WRITE   | writing nxt_q rows 0..3 back to memory
// DONE    | one-cycle done pulse; start here chains straight into READ
module life_step_engine #(
    parameter bit WRAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    life_step_engine_if.master bus
);
    typedef enum logic [2:0] {IDLE, READ, COMPUTE, WRITE, DONE} state_t;

    state_t           state_q;
    logic [2:0]       rd_cnt_q;
    logic [1:0]       wr_cnt_q;
    logic [3:0][15:0] cur_q;
    logic [3:0][15:0] nxt_q;
    logic [3:0][15:0] nxt_d;
    logic [1:0]       sel_q;
    logic [15:0]      wdata_q;
    logic             wen_q;
    logic             busy_q;
    logic             done_q;
    logic [15:0]      gen_q;

    // Bit c of the result is the neighbour at column c-1 (west) or c+1 (east).
    function automatic logic [15:0] west_of(input logic [15:0] v);
        return {v[14:0], WRAP ? v[15] : 1'b0};
    endfunction

    function automatic logic [15:0] east_of(input logic [15:0] v);
        return {WRAP ? v[0] : 1'b0, v[15:1]};
    endfunction

    logic [7:0][15:0] nb;
    logic [15:0]      up_v;
    logic [15:0]      mid_v;
    logic [15:0]      dn_v;
    logic [3:0]       n;

    always_comb begin
        nxt_d = '0;
        nb    = '0;
        up_v  = '0;
        mid_v = '0;
        dn_v  = '0;
        n     = '0;
        for (int r = 0; r < 4; r++) begin
            mid_v = cur_q[2'(r)];
            up_v  = (r == 0 && !WRAP) ? 16'h0000 : cur_q[2'(r + 3)];
            dn_v  = (r == 3 && !WRAP) ? 16'h0000 : cur_q[2'(r + 1)];
            nb = {west_of(up_v), up_v, east_of(up_v),
                  west_of(mid_v), east_of(mid_v),
                  west_of(dn_v), dn_v, east_of(dn_v)};
            for (int c = 0; c < 16; c++) begin
                n = '0;
                for (int k = 0; k < 8; k++) begin
                    n = n + {3'b000, nb[3'(k)][4'(c)]};
                end
                nxt_d[2'(r)][4'(c)] = (n == 4'd3) | (mid_v[4'(c)] & (n == 4'd2));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            cur_q    <= '0;
            nxt_q    <= '0;
            sel_q    <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gen_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q  <= READ;
                        rd_cnt_q <= '0;
                        sel_q    <= '0;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                READ: begin
                    // Memory returns the row one cycle after its address.
                    if (rd_cnt_q != 3'd0) begin
                        cur_q[rd_cnt_q[1:0] - 2'd1] <= bus.alive_out_selector;
                    end
                    if (rd_cnt_q == 3'd4) begin
                        state_q <= COMPUTE;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 3'd1;
                        sel_q    <= (rd_cnt_q >= 3'd3) ? 2'd3 : rd_cnt_q[1:0] + 2'd1;
                    end
                end
                COMPUTE: begin
                    nxt_q    <= nxt_d;
                    state_q  <= WRITE;
                    wr_cnt_q <= '0;
                    sel_q    <= '0;
                    wen_q    <= 1'b1;
                    wdata_q  <= nxt_d[0];
                end
                WRITE: begin
                    if (wr_cnt_q == 2'd3) begin
                        state_q <= DONE;
                        sel_q   <= '0;
                        wen_q   <= 1'b0;
                        wdata_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        gen_q   <= gen_q + 16'd1;
                    end else begin
                        wr_cnt_q <= wr_cnt_q + 2'd1;
                        sel_q    <= wr_cnt_q + 2'd1;
                        wdata_q  <= nxt_q[wr_cnt_q + 2'd1];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.array_selector    = sel_q;
    assign bus.alive_in_selector = wdata_q;
    assign bus.write_enb         = wen_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.gen_count         = gen_q;
endmodule

// File: tb/tb_life_step_engine.sv
// Bench for life_step_engine: toroidal and dead-edge instances, each on its own
// registered-address memory model, checked against a cell-by-cell Life model.
module tb_life_step_engine;
    typedef logic [3:0][15:0] grid_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    life_step_engine_if if_w();
    life_step_engine_if if_d();

    life_step_engine #(.WRAP(1'b1)) dut_w (.clk(clk), .rst(rst), .bus(if_w.master));
    life_step_engine #(.WRAP(1'b0)) dut_d (.clk(clk), .rst(rst), .bus(if_d.master));

    logic [15:0] mem_w [4];
    logic [15:0] mem_d [4];
    logic [1:0]  addr_w = 2'd0;
    logic [1:0]  addr_d = 2'd0;

    always @(posedge clk) begin
        addr_w <= if_w.array_selector;
        addr_d <= if_d.array_selector;
        if (if_w.write_enb) mem_w[if_w.array_selector] <= if_w.alive_in_selector;
        if (if_d.write_enb) mem_d[if_d.array_selector] <= if_d.alive_in_selector;
    end
    assign if_w.alive_out_selector = mem_w[addr_w];
    assign if_d.alive_out_selector = mem_d[addr_d];

    int          errors = 0;
    int          checks = 0;
    bit          use_d;
    logic [15:0] gen_w;
    logic [15:0] gen_d;

    wire [1:0]  o_sel  = use_d ? if_d.array_selector    : if_w.array_selector;
    wire [15:0] o_wd   = use_d ? if_d.alive_in_selector : if_w.alive_in_selector;
    wire        o_we   = use_d ? if_d.write_enb         : if_w.write_enb;
    wire        o_busy = use_d ? if_d.busy              : if_w.busy;
    wire        o_done = use_d ? if_d.done              : if_w.done;
    wire [15:0] o_gen  = use_d ? if_d.gen_count         : if_w.gen_count;

    logic [2:0]  tr_ctrl [33];
    logic [1:0]  tr_sel  [33];
    logic [15:0] tr_wd   [33];
    logic [15:0] tr_gen  [33];

    // Reference: count the eight neighbours of every cell directly.
    function automatic grid_t life_model(input grid_t g, input bit wrap);
        grid_t ng = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 16; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (wrap) begin
                            rr = (rr + 4) % 4;
                            cc = (cc + 16) % 16;
                        end else if (rr < 0 || rr > 3 || cc < 0 || cc > 15) begin
                            continue;
                        end
                        if (g[2'(rr)][4'(cc)]) n++;
                    end
                end
                ng[2'(r)][4'(c)] = (n == 3) || (g[2'(r)][4'(c)] && n == 2);
            end
        end
        return ng;
    endfunction

    task automatic load(input grid_t g);
        for (int r = 0; r < 4; r++) begin
            if (use_d) mem_d[r] = g[2'(r)];
            else       mem_w[r] = g[2'(r)];
        end
    endtask

    function automatic grid_t read_mem();
        grid_t g;
        for (int r = 0; r < 4; r++) g[2'(r)] = use_d ? mem_d[r] : mem_w[r];
        return g;
    endfunction

    task automatic drive_start(input bit v);
        if (use_d) if_d.start = v;
        else       if_w.start = v;
    endtask

    // Issue a start and record nsteps*11 cycles; with hold the start stays high.
    task automatic run_steps(input int nsteps, input bit hold);
        @(negedge clk);
        drive_start(1'b1);
        for (int k = 0; k < 11 * nsteps; k++) begin
            @(negedge clk);
            if (k == (hold ? 11 * nsteps - 1 : 0)) drive_start(1'b0);
            tr_ctrl[k] = {o_busy, o_we, o_done};
            tr_sel[k]  = o_sel;
            tr_wd[k]   = o_wd;
            tr_gen[k]  = o_gen;
        end
    endtask

    function automatic logic [32:0] got_ctrl(input int s);
        logic [32:0] v;
        for (int k = 0; k < 11; k++) v[3*k +: 3] = tr_ctrl[11*s + k];
        return v;
    endfunction

    // {busy, write_enb, done} per cycle 0..10 of a step.
    function automatic logic [32:0] exp_ctrl();
        logic [32:0] v;
        for (int k = 0; k < 11; k++) v[3*k +: 3] = {(k <= 9), (k >= 6 && k <= 9), (k == 10)};
        return v;
    endfunction

    function automatic logic [17:0] got_sel(input int s);
        logic [17:0] v;
        for (int k = 0; k < 5; k++) v[2*k +: 2] = tr_sel[11*s + k];
        for (int k = 6; k < 10; k++) v[2*(k-1) +: 2] = tr_sel[11*s + k];
        return v;
    endfunction

    function automatic logic [17:0] exp_sel();
        logic [17:0] v;
        for (int k = 0; k < 5; k++) v[2*k +: 2] = (k < 4) ? 2'(k) : 2'd3;
        for (int k = 6; k < 10; k++) v[2*(k-1) +: 2] = 2'(k - 6);
        return v;
    endfunction

    function automatic grid_t got_wd(input int s);
        grid_t g;
        for (int j = 0; j < 4; j++) g[2'(j)] = tr_wd[11*s + 6 + j];
        return g;
    endfunction

    task automatic test_reset();
        #3;
        checks++;
        if ({if_w.array_selector, if_w.alive_in_selector, if_w.write_enb, if_w.busy,
             if_w.done, if_w.gen_count} !== 37'd0) begin
            errors++;
            $display("FAIL reset_wrap: got sel=%h wd=%h we=%b busy=%b done=%b gen=%h exp all zero",
                     if_w.array_selector, if_w.alive_in_selector, if_w.write_enb, if_w.busy,
                     if_w.done, if_w.gen_count);
        end
        checks++;
        if ({if_d.array_selector, if_d.alive_in_selector, if_d.write_enb, if_d.busy,
             if_d.done, if_d.gen_count} !== 37'd0) begin
            errors++;
            $display("FAIL reset_dead: got sel=%h wd=%h we=%b busy=%b done=%b gen=%h exp all zero",
                     if_d.array_selector, if_d.alive_in_selector, if_d.write_enb, if_d.busy,
                     if_d.done, if_d.gen_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_blinker();
        grid_t exp_g = {16'h0000, 16'h0200, 16'h0200, 16'h0200};
        use_d = 1'b0;
        load({16'h0000, 16'h0000, 16'h0700, 16'h0000});
        run_steps(1, 1'b0);
        gen_w++;
        checks++;
        if ({got_ctrl(0), got_sel(0), tr_gen[10]} !== {exp_ctrl(), exp_sel(), gen_w}) begin
            errors++;
            $display("FAIL blinker_timing: got %h exp %h",
                     {got_ctrl(0), got_sel(0), tr_gen[10]}, {exp_ctrl(), exp_sel(), gen_w});
        end
        checks++;
        if ({got_wd(0), read_mem()} !== {exp_g, exp_g}) begin
            errors++;
            $display("FAIL blinker_rows: got %h exp %h", {got_wd(0), read_mem()}, {exp_g, exp_g});
        end
    endtask

    task automatic test_still_life();
        grid_t blk = {16'h0000, 16'h0180, 16'h0180, 16'h0000};
        use_d = 1'b0;
        load(blk);
        for (int i = 0; i < 2; i++) begin
            run_steps(1, 1'b0);
            gen_w++;
            checks++;
            if ({got_wd(0), read_mem(), tr_gen[10]} !== {blk, blk, gen_w}) begin
                errors++;
                $display("FAIL still_life_%0d: got %h exp %h", i,
                         {got_wd(0), read_mem(), tr_gen[10]}, {blk, blk, gen_w});
            end
        end
    endtask

    task automatic test_wrap_boundary();
        grid_t seed  = {16'h0000, 16'h0000, 16'h8003, 16'h0000};
        grid_t exp_w = {16'h0000, 16'h0001, 16'h0001, 16'h0001};
        use_d = 1'b0;
        load(seed);
        run_steps(1, 1'b0);
        gen_w++;
        checks++;
        if ({got_wd(0), read_mem(), tr_gen[10]} !== {exp_w, exp_w, gen_w}) begin
            errors++;
            $display("FAIL wrap_torus: got %h exp %h", {got_wd(0), read_mem(), tr_gen[10]},
                     {exp_w, exp_w, gen_w});
        end
        use_d = 1'b1;
        load(seed);
        run_steps(1, 1'b0);
        gen_d++;
        checks++;
        if ({got_ctrl(0), got_sel(0), got_wd(0), read_mem(), tr_gen[10]} !==
            {exp_ctrl(), exp_sel(), 64'd0, 64'd0, gen_d}) begin
            errors++;
            $display("FAIL wrap_dead_edge: got %h exp %h",
                     {got_ctrl(0), got_sel(0), got_wd(0), read_mem(), tr_gen[10]},
                     {exp_ctrl(), exp_sel(), 64'd0, 64'd0, gen_d});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            grid_t g = {$urandom(), $urandom()};
            grid_t e;
            use_d = i[0];
            e = life_model(g, !use_d);
            load(g);
            run_steps(1, 1'b0);
            if (use_d) gen_d++;
            else       gen_w++;
            checks++;
            if ({got_ctrl(0), got_wd(0), read_mem(), tr_gen[10]} !==
                {exp_ctrl(), e, e, use_d ? gen_d : gen_w}) begin
                errors++;
                $display("FAIL random_%0d: got %h exp %h", i,
                         {got_ctrl(0), got_wd(0), read_mem(), tr_gen[10]},
                         {exp_ctrl(), e, e, use_d ? gen_d : gen_w});
            end
        end
    endtask

    task automatic test_back_to_back();
        grid_t e = {$urandom(), $urandom()};
        bit quiet = 1'b1;
        use_d = 1'b0;
        load(e);
        run_steps(3, 1'b1);
        for (int s = 0; s < 3; s++) begin
            e = life_model(e, 1'b1);
            checks++;
            if ({got_ctrl(s), got_sel(s), got_wd(s), tr_gen[11*s + 10]} !==
                {exp_ctrl(), exp_sel(), e, gen_w + 16'(s + 1)}) begin
                errors++;
                $display("FAIL held_start_step%0d: got %h exp %h", s,
                         {got_ctrl(s), got_sel(s), got_wd(s), tr_gen[11*s + 10]},
                         {exp_ctrl(), exp_sel(), e, gen_w + 16'(s + 1)});
            end
        end
        gen_w += 16'd3;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (o_we || o_busy || o_gen !== gen_w) quiet = 1'b0;
        end
        checks++;
        if ({quiet, read_mem()} !== {1'b1, e}) begin
            errors++;
            $display("FAIL held_start_after: got quiet=%b mem=%h exp quiet=1 mem=%h",
                     quiet, read_mem(), e);
        end
    endtask

    task automatic test_reset_mid_read();
        grid_t g = {$urandom(), $urandom()};
        bit quiet = 1'b1;
        use_d = 1'b0;
        load(g);
        @(negedge clk);
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        gen_w = '0;
        gen_d = '0;
        checks++;
        if ({o_sel, o_wd, o_we, o_busy, o_done, o_gen} !== 37'd0) begin
            errors++;
            $display("FAIL rst_mid_read: got sel=%h wd=%h we=%b busy=%b done=%b gen=%h exp all zero",
                     o_sel, o_wd, o_we, o_busy, o_done, o_gen);
        end
        #1 rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (o_we || o_busy || o_gen !== 16'd0) quiet = 1'b0;
        end
        checks++;
        if ({quiet, read_mem()} !== {1'b1, g}) begin
            errors++;
            $display("FAIL rst_mid_read_quiet: got quiet=%b mem=%h exp quiet=1 mem=%h",
                     quiet, read_mem(), g);
        end
    endtask

    task automatic test_reset_mid_write();
        grid_t old_g = {$urandom(), $urandom()};
        grid_t new_g = life_model(old_g, 1'b1);
        grid_t mix_g = {old_g[3], old_g[2], new_g[1], new_g[0]};
        grid_t e     = life_model(mix_g, 1'b1);
        use_d = 1'b0;
        load(old_g);
        @(negedge clk);
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        // Rows 0 and 1 have been committed by the edge that opens cycle 8.
        repeat (8) @(negedge clk);
        checks++;
        if ({o_we, o_sel} !== 3'b110) begin
            errors++;
            $display("FAIL rst_mid_write_pre: got we=%b sel=%h exp we=1 sel=2", o_we, o_sel);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({o_we, o_busy, o_done, o_sel, o_wd, o_gen} !== 37'd0) begin
            errors++;
            $display("FAIL rst_mid_write: got we=%b busy=%b done=%b sel=%h wd=%h gen=%h exp all zero",
                     o_we, o_busy, o_done, o_sel, o_wd, o_gen);
        end
        #1 rst = 1'b0;
        checks++;
        if (read_mem() !== mix_g) begin
            errors++;
            $display("FAIL rst_mid_write_mem: got %h exp %h", read_mem(), mix_g);
        end
        run_steps(1, 1'b0);
        checks++;
        if ({got_ctrl(0), got_sel(0), got_wd(0), read_mem(), tr_gen[10]} !==
            {exp_ctrl(), exp_sel(), e, e, 16'd1}) begin
            errors++;
            $display("FAIL rst_mid_write_restart: got %h exp %h",
                     {got_ctrl(0), got_sel(0), got_wd(0), read_mem(), tr_gen[10]},
                     {exp_ctrl(), exp_sel(), e, e, 16'd1});
        end
    endtask

    initial begin
        rst        = 1'b1;
        if_w.start = 1'b0;
        if_d.start = 1'b0;
        use_d      = 1'b0;
        gen_w      = '0;
        gen_d      = '0;
        test_reset();
        test_blinker();
        test_still_life();
        test_wrap_boundary();
        test_random();
        test_back_to_back();
        test_reset_mid_read();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
